systolic_array_mxn: RTL and testbench

Parametrised output-stationary systolic matrix-multiply engine: computes C = A·B for A (ROWS×K) and B (K×COLS), with K set per job at run time. It supersedes the fixed 2×2 array. It adds internal input skewing, per-PE accumulation, valid/ready streaming on both sides and a control FSM that sequences clear, stream, flush and drain. It sits between the operand fetch logic and the result writeback path.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_pe_mac.sv | 48 ++++
 rtl/systolic_array_mxn.sv | 170 +++++++++++++++++
 tb/tb_systolic_array_mxn.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
// FSM states, accumulator sizing and packed-lane offsets.
package sa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DRAIN
    } sa_state_e;

    function automatic int default_acc_width(input int data_width,
                                             input int max_k);
        return 2 * data_width + $clog2(max_k);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sa_pe_mac.sv
// Single processing element: registers a/b for its neighbours and
// accumulates their signed product, wrapping at ACC_WIDTH bits.
module sa_pe_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    logic [DATA_WIDTH-1:0]          r_a;
    logic [DATA_WIDTH-1:0]          r_b;
    logic [ACC_WIDTH-1:0]           r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]           w_prod_ext;

    assign w_prod     = $signed(i_a) * $signed(i_b);
    // size cast of a signed value sign-extends the full product
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_en) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_mxn.sv
// ROWS x COLS output-stationary matrix-multiply engine with input skew,
// clear/stream/flush/drain sequencing and valid/ready on both sides.
module systolic_array_mxn
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 8,
    parameter int ACC_WIDTH  = default_acc_width(DATA_WIDTH,
                                                 (1 << K_WIDTH) - 1)
) (
    input  logic                      sa_clk,
    input  logic                      sa_rst,
    input  logic                      sa_start,
    input  logic [K_WIDTH-1:0]        sa_k_len,
    input  logic                      sa_in_valid,
    output logic                      sa_in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] sa_a_in,
    input  logic [COLS*DATA_WIDTH-1:0] sa_b_in,
    output logic                      sa_out_valid,
    input  logic                      sa_out_ready,
    output logic [COLS*ACC_WIDTH-1:0] sa_c_out,
    output logic                      sa_busy,
    output logic                      sa_done
);

    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

    sa_state_e            r_state;
    sa_state_e            w_next;
    logic [K_WIDTH-1:0]   r_k_len;
    logic [K_WIDTH-1:0]   r_beat;
    logic [FW-1:0]        r_flush;
    logic [RW-1:0]        r_row;
    logic                 r_done;

    logic w_accept;
    logic w_last_beat;
    logic w_flush_end;
    logic w_row_hs;
    logic w_last_row;
    logic w_en;
    logic w_clr;

    logic [DATA_WIDTH-1:0] w_a_h [ROWS][COLS+1];
    logic [DATA_WIDTH-1:0] w_b_v [ROWS+1][COLS];
    logic [ACC_WIDTH-1:0]  w_acc [ROWS][COLS];

    assign w_accept    = (r_state == S_STREAM) & sa_in_valid;
    assign w_last_beat = w_accept & (r_beat == r_k_len - K_WIDTH'(1));
    assign w_flush_end = (r_flush == FW'(FLUSH_LEN - 1));
    assign w_row_hs    = (r_state == S_DRAIN) & sa_out_ready;
    assign w_last_row  = w_row_hs & (r_row == RW'(ROWS - 1));
    assign w_en        = (r_state == S_STREAM) | (r_state == S_FLUSH);
    assign w_clr       = (r_state == S_CLEAR);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (sa_start) w_next = S_CLEAR;
            S_CLEAR:  w_next = (r_k_len == '0) ? S_FLUSH : S_STREAM;
            S_STREAM: if (w_last_beat) w_next = S_FLUSH;
            S_FLUSH:  if (w_flush_end) w_next = S_DRAIN;
            S_DRAIN:  if (w_last_row) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sa_clk or posedge sa_rst) begin
        if (sa_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge sa_clk or posedge sa_rst) begin
        if (sa_rst) begin
            r_k_len <= '0;
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last_row;
            if ((r_state == S_IDLE) && sa_start) begin
                r_k_len <= sa_k_len;
            end
            r_beat  <= (r_state == S_STREAM) ?
                       r_beat + K_WIDTH'(w_accept) : '0;
            r_flush <= (r_state == S_FLUSH) ? r_flush + FW'(1) : '0;
            r_row   <= (r_state == S_DRAIN) ?
                       r_row + RW'(w_row_hs) : '0;
        end
    end

    assign sa_in_ready  = (r_state == S_STREAM);
    assign sa_out_valid = (r_state == S_DRAIN);
    assign sa_busy      = (r_state != S_IDLE);
    assign sa_done      = r_done;

    // row r of A and column c of B enter r (resp. c) cycles late
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [DATA_WIDTH-1:0] w_a_in;
        assign w_a_in = w_accept ?
            sa_a_in[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] : '0;
        if (r == 0) begin : g_direct
            assign w_a_h[0][0] = w_a_in;
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] r_sk [r];
            always_ff @(posedge sa_clk or posedge sa_rst) begin
                if (sa_rst || w_clr) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else if (w_en) begin
                    r_sk[0] <= w_a_in;
                    for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_a_h[r][0] = r_sk[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic [DATA_WIDTH-1:0] w_b_in;
        assign w_b_in = w_accept ?
            sa_b_in[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH] : '0;
        if (c == 0) begin : g_direct
            assign w_b_v[0][0] = w_b_in;
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] r_sk [c];
            always_ff @(posedge sa_clk or posedge sa_rst) begin
                if (sa_rst || w_clr) begin
                    for (int i = 0; i < c; i++) r_sk[i] <= '0;
                end else if (w_en) begin
                    r_sk[0] <= w_b_in;
                    for (int i = 1; i < c; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_b_v[0][c] = r_sk[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sa_pe_mac #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .i_clk (sa_clk),
                .i_rst (sa_rst),
                .i_clr (w_clr),
                .i_en  (w_en),
                .i_a   (w_a_h[r][c]),
                .i_b   (w_b_v[r][c]),
                .o_a   (w_a_h[r][c+1]),
                .o_b   (w_b_v[r+1][c]),
                .o_acc (w_acc[r][c])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_out
        assign sa_c_out[lane_lsb(c, ACC_WIDTH) +: ACC_WIDTH] =
            sa_out_valid ? w_acc[r_row][c] : '0;
    end

endmodule

// File: tb/tb_systolic_array_mxn.sv
// Bench for systolic_array_mxn: a 4x4/16-bit and a 2x2/8-bit instance
// checked against a plain matrix-product reference model.
module tb_systolic_array_mxn;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         s0, iv0, or0;
    logic [7:0]   k0;
    logic [63:0]  a0, b0;
    logic         ir0, ov0, busy0, done0;
    logic [159:0] c0;

    logic         s1, iv1, or1;
    logic [7:0]   k1;
    logic [15:0]  a1, b1;
    logic         ir1, ov1, busy1, done1;
    logic [31:0]  c1;

    systolic_array_mxn #(
        .DATA_WIDTH(16), .ROWS(4), .COLS(4), .K_WIDTH(8), .ACC_WIDTH(40)
    ) u_dut (
        .sa_clk(clk), .sa_rst(rst), .sa_start(s0), .sa_k_len(k0),
        .sa_in_valid(iv0), .sa_in_ready(ir0), .sa_a_in(a0),
        .sa_b_in(b0), .sa_out_valid(ov0), .sa_out_ready(or0),
        .sa_c_out(c0), .sa_busy(busy0), .sa_done(done0)
    );

    systolic_array_mxn #(
        .DATA_WIDTH(8), .ROWS(2), .COLS(2), .K_WIDTH(8), .ACC_WIDTH(16)
    ) u_small (
        .sa_clk(clk), .sa_rst(rst), .sa_start(s1), .sa_k_len(k1),
        .sa_in_valid(iv1), .sa_in_ready(ir1), .sa_a_in(a1),
        .sa_b_in(b1), .sa_out_valid(ov1), .sa_out_ready(or1),
        .sa_c_out(c1), .sa_busy(busy1), .sa_done(done1)
    );

    int n_err = 0;
    int n_chk = 0;
    int A [4][16];
    int B [16][4];
    int sel, nR, nC, dw, aw;

    typedef struct {
        int d; int kl; int pat; int bub; int sat; int sn;
        logic [63:0] e00; logic [63:0] elast;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic cur_ir();   return sel ? ir1 : ir0;     endfunction
    function automatic logic cur_ov();   return sel ? ov1 : ov0;     endfunction
    function automatic logic cur_busy(); return sel ? busy1 : busy0; endfunction
    function automatic logic cur_done(); return sel ? done1 : done0; endfunction
    function automatic logic [63:0] cur_c(input int c);
        return sel ? 64'(c1[c*16 +: 16]) : 64'(c0[c*40 +: 40]);
    endfunction
    function automatic logic [159:0] cur_row();
        return sel ? 160'(c1) : c0;
    endfunction

    function automatic logic [63:0] model(input int r, input int c,
                                          input int kl);
        longint s = 0;
        logic [63:0] mask = (64'(1) << aw) - 64'(1);
        for (int k = 0; k < kl; k++) s += longint'(A[r][k]) * longint'(B[k][c]);
        return 64'(s) & mask;
    endfunction

    task automatic fill(input int pat);
        logic [15:0] rv;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 16; k++) begin
                case (pat)
                    0: A[r][k] = (r < 2 && k < 2) ? r * 2 + k + 1 : 0;
                    1: A[r][k] = r + k;
                    2: A[r][k] = 127;
                    default: begin
                        rv = 16'($urandom);
                        A[r][k] = (dw == 8) ? int'($signed(rv[7:0]))
                                            : int'($signed(rv));
                    end
                endcase
                case (pat)
                    0: B[k][r] = (k == r) ? 1 : 0;
                    1: B[k][r] = k - r;
                    2: B[k][r] = 127;
                    default: begin
                        rv = 16'($urandom);
                        B[k][r] = (dw == 8) ? int'($signed(rv[7:0]))
                                            : int'($signed(rv));
                    end
                endcase
            end
    endtask

    task automatic drive_beat(input logic v, input int k);
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; iv0 = 1'b0; iv1 = 1'b0;
        if (sel == 1) begin
            iv1 = v;
            if (v) for (int i = 0; i < 2; i++) begin
                a1[i*8 +: 8] = A[i][k][7:0];
                b1[i*8 +: 8] = B[k][i][7:0];
            end
        end else begin
            iv0 = v;
            if (v) for (int i = 0; i < 4; i++) begin
                a0[i*16 +: 16] = A[i][k][15:0];
                b0[i*16 +: 16] = B[k][i][15:0];
            end
        end
    endtask

    task automatic set_start(input logic s, input int kl);
        if (sel == 1) begin s1 = s; k1 = 8'(kl); end
        else begin s0 = s; k0 = 8'(kl); end
    endtask

    task automatic set_or(input logic v);
        if (sel == 1) or1 = v; else or0 = v;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {ir0, ov0, busy0, done0, ir1, ov1, busy1, done1}, 0);
        chk({nm, "_c0"}, 64'(c0 == '0), 1);
        chk({nm, "_c1"}, 64'(c1), 0);
    endtask

    task automatic run_job(input int d, input int kl, input int pat,
                           input int bub, input int sat, input int sn,
                           output logic [63:0] g00, output logic [63:0] glast);
        int k, it, lat, row, cyc, stl;
        logic v, rdy;
        logic [63:0] got;
        logic [159:0] snap;
        sel = d; nR = d ? 2 : 4; nC = nR; dw = d ? 8 : 16; aw = d ? 16 : 40;
        g00 = '1; glast = '1; snap = '0;
        fill(pat);
        @(negedge clk); set_start(1'b1, kl);
        @(negedge clk); set_start(1'b0, 0);
        chk("clear_busy", cur_busy(), 1);
        chk("clear_not_ready", cur_ir(), 0);
        @(negedge clk);
        chk("stream_ready", cur_ir(), kl > 0);
        k = 0; it = 0;
        while (k < kl && it < 400) begin
            v = (bub == 0) ? 1'b1 : (bub == 1) ? (it % 2 == 0)
                                               : ($urandom_range(0, 2) != 0);
            drive_beat(v, k);
            if (v && cur_ir()) k++;
            @(negedge clk); it++;
        end
        drive_beat(1'b0, 0);
        if (k < kl) chk("stream_timeout", k, kl);
        lat = 1;
        while (!cur_ov() && lat < 200) begin @(negedge clk); lat++; end
        if (kl > 0) chk("latency", lat, nR + nC);
        else chk("zero_k_drain", cur_ov(), 1);
        row = 0; cyc = 0; stl = 0;
        while (row < nR && cyc < 200) begin
            rdy = !(row == sat && stl < sn);
            if (!rdy) begin
                if (stl == 0) snap = cur_row();
                else chk("stall_hold", 64'(cur_row() == snap), 1);
                stl++;
            end
            set_or(rdy);
            if (cur_ov() && rdy) begin
                for (int c = 0; c < nC; c++) begin
                    got = cur_c(c);
                    chk("c_out", got, model(row, c, kl));
                    if (row == 0 && c == 0) g00 = got;
                    if (row == nR - 1 && c == nC - 1) glast = got;
                end
                row++;
            end
            @(negedge clk); cyc++;
        end
        set_or(1'b1);
        chk("drain_cycles", cyc, nR + sn);
        chk("done_pulse", cur_done(), 1);
        chk("idle_after_done", cur_busy(), 0);
        @(negedge clk);
        chk("done_one_cycle", cur_done(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] g00, glast;
        int lim;
        tbl[0] = '{1, 2, 0, 0, -1, 0, 64'd1, 64'd4};
        tbl[1] = '{0, 3, 1, 1, -1, 0, 64'd5, 64'hFF_FFFF_FFEA};
        tbl[2] = '{0, 3, 1, 0, 2, 5, 64'd5, 64'hFF_FFFF_FFEA};
        tbl[3] = '{0, 0, 3, 0, -1, 0, 64'd0, 64'd0};
        tbl[4] = '{1, 8, 2, 0, -1, 0, 64'hF808, 64'hF808};
        tbl[5] = '{1, 0, 3, 0, 1, 2, 64'd0, 64'd0};

        rst = 1'b1; sel = 0;
        s0 = 0; k0 = 0; iv0 = 0; a0 = 0; b0 = 0; or0 = 1;
        s1 = 0; k1 = 0; iv1 = 0; a1 = 0; b1 = 0; or1 = 1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i].d, tbl[i].kl, tbl[i].pat, tbl[i].bub,
                    tbl[i].sat, tbl[i].sn, g00, glast);
            chk("tbl_c00", g00, tbl[i].e00);
            chk("tbl_clast", glast, tbl[i].elast);
        end

        sel = 0; nR = 4; nC = 4; dw = 16; aw = 40;
        fill(3);
        @(negedge clk); set_start(1'b1, 5);
        @(negedge clk); set_start(1'b0, 0);
        @(negedge clk); drive_beat(1'b1, 0);
        @(negedge clk); drive_beat(1'b1, 1);
        @(negedge clk); drive_beat(1'b0, 0);
        rst = 1'b1;
        #1 chk_zero("rst_stream");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_stream_no_done", {done0, busy0}, 0);

        @(negedge clk); set_start(1'b1, 2);
        @(negedge clk); set_start(1'b0, 0);
        @(negedge clk); drive_beat(1'b1, 0);
        @(negedge clk); drive_beat(1'b1, 1);
        @(negedge clk); drive_beat(1'b0, 0);
        lim = 0;
        while (!ov0 && lim < 50) begin @(negedge clk); lim++; end
        chk("rst_drain_reached", ov0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_zero("rst_drain");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_drain_no_done", {done0, busy0}, 0);

        for (int i = 0; i < 8; i++) begin
            int d;
            d = (i % 4 == 3) ? 1 : 0;
            run_job(d, $urandom_range(1, 12), 3, 2,
                    $urandom_range(0, d ? 1 : 3), $urandom_range(0, 3),
                    g00, glast);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
